int_to_fp_converter: RTL and testbench

//  Sequential converter: signed two's-complement integer -> fp format {sign, exp[3:0], frac[7:0]}.

---
 rtl/int_to_fp_converter_if.sv | 24 ++
 rtl/int_to_fp_converter.sv | 137 +++++++++++++
 tb/tb_int_to_fp_converter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/int_to_fp_converter_if.sv
// Request/result bundle between an integer datapath and int_to_fp_converter.
// Master drives start/int_in; slave returns ready/done and the fp fields.
interface int_to_fp_converter_if #(
  parameter int IN_W = 16
);
  logic            start;
  logic [IN_W-1:0] int_in;
  logic            ready;
  logic            done;
  logic            sign_out;
  logic [3:0]      exp_out;
  logic [7:0]      frac_out;
  logic            ovf;

  modport master (
    output start, int_in,
    input  ready, done, sign_out, exp_out, frac_out, ovf
  );

  modport slave (
    input  start, int_in,
    output ready, done, sign_out, exp_out, frac_out, ovf
  );
endinterface

// File: rtl/int_to_fp_converter.sv
// Sequential signed-int to {sign, exp[3:0], frac[7:0]} converter.
// Define INT2FP_ROUND_EN for round-to-nearest-even, otherwise truncates.
module int_to_fp_converter #(
  parameter int IN_W = 16
) (
  input logic clk,
  input logic reset_n,
  int_to_fp_converter_if.slave io
);

  localparam int EW = $clog2(IN_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    ROUND
  } state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] mag_q, mag_d;
  logic [EW-1:0]   e_q, e_d;
  logic            sgn_q, sgn_d;
  logic            done_q, done_d;
  logic            sign_q, sign_d;
  logic [3:0]      exp_q, exp_d;
  logic [7:0]      frac_q, frac_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      f_w;
  logic            inc_w;
  logic [8:0]      fsum_w;
  logic [EW:0]     efin_w;
  logic            ovf_w;

  assign f_w = mag_q[IN_W-1 -: 8];

`ifdef INT2FP_ROUND_EN
  localparam logic [IN_W-1:0] S_MASK =
    IN_W'((64'd1 << (IN_W - 10)) - 64'd1);
  logic g_w, r_w, s_w;
  assign g_w   = mag_q[IN_W-9];
  assign r_w   = mag_q[IN_W-10];
  assign s_w   = |(mag_q & S_MASK);
  assign inc_w = g_w & (r_w | s_w | f_w[0]);
`else
  assign inc_w = 1'b0;
`endif

  // A carry out of the fraction renormalises to 0.1 and bumps e.
  assign fsum_w = {1'b0, f_w} + {8'd0, inc_w};
  assign efin_w = {1'b0, e_q} + {{EW{1'b0}}, fsum_w[8]};
  assign ovf_w  = efin_w > (EW+1)'(15);

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    e_d     = e_q;
    sgn_d   = sgn_q;
    done_d  = 1'b0;
    sign_d  = sign_q;
    exp_d   = exp_q;
    frac_d  = frac_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (io.start) begin
          sgn_d   = io.int_in[IN_W-1];
          mag_d   = io.int_in[IN_W-1] ? -io.int_in
                                      : io.int_in;
          e_d     = EW'(IN_W);
          state_d = NORM;
        end
      end
      NORM: begin
        if (mag_q == '0 || mag_q[IN_W-1]) begin
          state_d = ROUND;
        end else begin
          mag_d = mag_q << 1;
          e_d   = e_q - EW'(1);
        end
      end
      ROUND: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (mag_q == '0) begin
          sign_d = 1'b0;
          exp_d  = 4'h0;
          frac_d = 8'h00;
          ovf_d  = 1'b0;
        end else if (ovf_w) begin
          sign_d = sgn_q;
          exp_d  = 4'hF;
          frac_d = 8'hFF;
          ovf_d  = 1'b1;
        end else begin
          sign_d = sgn_q;
          exp_d  = efin_w[3:0];
          frac_d = fsum_w[8] ? 8'h80 : fsum_w[7:0];
          ovf_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mag_q   <= '0;
      e_q     <= '0;
      sgn_q   <= 1'b0;
      done_q  <= 1'b0;
      sign_q  <= 1'b0;
      exp_q   <= 4'h0;
      frac_q  <= 8'h00;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      e_q     <= e_d;
      sgn_q   <= sgn_d;
      done_q  <= done_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      frac_q  <= frac_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.ready    = (state_q == IDLE);
  assign io.done     = done_q;
  assign io.sign_out = sign_q;
  assign io.exp_out  = exp_q;
  assign io.frac_out = frac_q;
  assign io.ovf      = ovf_q;

endmodule

// File: tb/tb_int_to_fp_converter.sv
// Bench for int_to_fp_converter (IN_W=16): vector table, protocol
// corner cases and random operands against an arithmetic model.
module tb_int_to_fp_converter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  int_to_fp_converter_if #(.IN_W(16)) io ();

  int_to_fp_converter #(.IN_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] x;
    logic [13:0]        res;
    int                 lat;
  } vec_t;

  task automatic chk(input string n, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", n, got, exp);
    end
  endtask

  // Value-level reference: {sign, exp, frac, ovf} and latency.
  task automatic model(input logic signed [15:0] x,
                       output logic [13:0] res, output int lat);
    int v, m, p, e, f, sh, rem, half;
    logic s;
    v = x;
    s = (v < 0);
    m = s ? -v : v;
    if (m == 0) begin
      res = '0;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 17; i++) if ((m >> i) != 0) p = i;
    e = p + 1;
    if (p >= 7) begin
      sh  = p - 7;
      f   = m >> sh;
`ifdef INT2FP_ROUND_EN
      rem = m - (f << sh);
      half = (sh > 0) ? (1 << (sh - 1)) : 0;
      if (sh > 0 && (rem > half || (rem == half && f % 2 == 1)))
        f = f + 1;
`else
      rem = 0;
      half = 0;
`endif
      if (f == 256) begin
        f = 128;
        e = e + 1;
      end
    end else begin
      f = m << (7 - p);
    end
    if (e > 15) res = {s, 4'hF, 8'hFF, 1'b1};
    else res = {s, 4'(e), 8'(f), 1'b0};
    lat = 15 - p + 2;
  endtask

  function automatic logic [13:0] outs();
    return {io.sign_out, io.exp_out, io.frac_out, io.ovf};
  endfunction

  task automatic do_start(input logic signed [15:0] x);
    @(negedge clk);
    io.int_in = x;
    io.start  = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (io.done) begin
        cyc = i;
        return;
      end
    end
  endtask

  vec_t vecs[9];
  logic [13:0] exp_r, prev_r;
  int exp_l, cyc, held_bad;
  logic signed [15:0] rx;

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    io.start  = 1'b0;
    io.int_in = '0;

    vecs[0] = '{16'sd1,     {1'b0, 4'h1, 8'h80, 1'b0}, 17};
    vecs[1] = '{-16'sd3,    {1'b1, 4'h2, 8'hC0, 1'b0}, 16};
    vecs[2] = '{16'sd0,     14'd0,                     2};
    vecs[3] = '{16'sd257,   {1'b0, 4'h9, 8'h80, 1'b0}, 9};
    vecs[4] = '{-16'sd32768,{1'b1, 4'hF, 8'hFF, 1'b1}, 2};
    vecs[5] = '{16'sd128,   {1'b0, 4'h8, 8'h80, 1'b0}, 10};
`ifdef INT2FP_ROUND_EN
    vecs[6] = '{16'sd259,   {1'b0, 4'h9, 8'h82, 1'b0}, 9};
    vecs[7] = '{16'sd511,   {1'b0, 4'hA, 8'h80, 1'b0}, 9};
    vecs[8] = '{16'sd32767, {1'b0, 4'hF, 8'hFF, 1'b1}, 3};
`else
    vecs[6] = '{16'sd259,   {1'b0, 4'h9, 8'h81, 1'b0}, 9};
    vecs[7] = '{16'sd511,   {1'b0, 4'h9, 8'hFF, 1'b0}, 9};
    vecs[8] = '{16'sd32767, {1'b0, 4'hF, 8'hFF, 1'b0}, 3};
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", io.ready, 1);
    chk("rst_done", io.done, 0);
    chk("rst_outs", outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_ready", io.ready, 1);
    chk("post_rst_outs", outs(), 0);

    foreach (vecs[k]) begin
      do_start(vecs[k].x);
      wait_done(cyc);
      chk($sformatf("vec%0d_res", k), outs(), vecs[k].res);
      chk($sformatf("vec%0d_lat", k), cyc, vecs[k].lat);
    end
    prev_r = outs();

    // Second start mid-NORM must be ignored; outputs must hold.
    do_start(16'sd1);
    cyc = -1;
    held_bad = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      io.start  = (i >= 3 && i <= 5);
      io.int_in = 16'sd5;
      if (io.done) begin
        cyc = i;
        break;
      end
      if (outs() !== prev_r) held_bad++;
    end
    io.start = 1'b0;
    chk("ignore_res", outs(), {1'b0, 4'h1, 8'h80, 1'b0});
    chk("ignore_lat", cyc, 17);
    chk("hold_norm", held_bad, 0);

    // Start in the done cycle is accepted back-to-back.
    io.int_in = -16'sd3;
    io.start  = 1'b1;
    @(posedge clk);
    #1;
    io.start = 1'b0;
    wait_done(cyc);
    chk("b2b_res", outs(), {1'b1, 4'h2, 8'hC0, 1'b0});
    chk("b2b_lat", cyc, 16);

    // Reset in the middle of normalisation.
    do_start(16'sd3);
    repeat (4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_ready", io.ready, 1);
    chk("midrst_done", io.done, 0);
    chk("midrst_outs", outs(), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_quiet", {io.done, outs()}, 0);

    for (int n = 0; n < 300; n++) begin
      rx = 16'($urandom);
      rx = rx >>> $urandom_range(0, 15);
      model(rx, exp_r, exp_l);
      do_start(rx);
      wait_done(cyc);
      chk($sformatf("rnd x=%0d res", rx), outs(), exp_r);
      chk($sformatf("rnd x=%0d lat", rx), cyc, exp_l);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
